dm_responder: RTL and testbench

//   Data-memory responder for the pipeline MEM stage. Accepts one load/store request
//   per valid/ready handshake and completes it after a fixed latency. Handles byte,

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/dm_responder_if.sv | 26 ++
 rtl/dm_lane_align.sv | 50 +++++
 rtl/dm_responder.sv | 148 ++++++++++++++
 tb/tb_dm_responder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size codes, FSM encoding and helpers for the data-memory responder
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = off[0];
            default:   is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response bundle between the MEM stage and the data-memory responder
interface dm_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte-lane steering for stores and lane extraction/extension for loads
module dm_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rword[{off, 3'b000} +: 8];
    assign rd_half = off[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata_sh   = '0;
        rdata_ext  = '0;
        misaligned = is_misaligned(size, off);
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = {{16{sext & rd_half[15]}}, rd_half};
            end
            default: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
        endcase
        // A misaligned access must never touch memory.
        if (misaligned) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - fixed-latency data-memory responder with byte lanes, sign extension and misalign flag
module dm_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dm_responder_if.slave     bus,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    state_t state;
    state_t state_nx;
    logic [3:0] cnt;

    logic              lat_we;
    logic              lat_sext;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;

    logic              use_live;
    logic              a_we;
    logic              a_sext;
    logic [1:0]        a_size;
    logic [1:0]        a_off;
    logic [ADDR_W-1:0] a_idx;
    logic [31:0]       a_wdata;

    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        accept;
    logic        commit;
    logic        unused_addr;

    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    assign accept = bus.req_valid && (state == ST_IDLE);

    // In IDLE the live request drives the lane logic so a LATENCY=1 store can commit on its accept edge.
    assign use_live = (state == ST_IDLE);
    assign a_we     = use_live ? bus.req_we                  : lat_we;
    assign a_sext   = use_live ? bus.req_sext                : lat_sext;
    assign a_size   = use_live ? bus.req_size                : lat_size;
    assign a_off    = use_live ? bus.req_addr[1:0]           : lat_off;
    assign a_idx    = use_live ? bus.req_addr[ADDR_W+1:2]    : lat_idx;
    assign a_wdata  = use_live ? bus.req_wdata               : lat_wdata;

    assign commit = a_we && !misaligned && (state_nx == ST_RESP) && (state != ST_RESP);

    dm_lane_align u_align (
        .size       (a_size),
        .sext       (a_sext),
        .off        (a_off),
        .wdata      (a_wdata),
        .rword      (mem[a_idx]),
        .be         (be),
        .wdata_sh   (wdata_sh),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == ST_IDLE);
        bus.busy      = (state != ST_IDLE);
        bus.rsp_valid = (state == ST_RESP);
        bus.rsp_err   = (state == ST_RESP) && misaligned;
        bus.rsp_rdata = '0;
        if ((state == ST_RESP) && !lat_we && !misaligned) begin
            bus.rsp_rdata = rdata_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_sext  <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_off   <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= 4'(LATENCY - 1);
            lat_we    <= bus.req_we;
            lat_sext  <= bus.req_sext;
            lat_size  <= bus.req_size;
            lat_off   <= bus.req_addr[1:0];
            lat_idx   <= bus.req_addr[ADDR_W+1:2];
            lat_wdata <= bus.req_wdata;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    mem[a_idx][8*n +: 8] <= wdata_sh[8*n +: 8];
                end
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - self-checking bench for dm_responder against a byte-level memory model
module tb_dm_responder;

    localparam int AW = 6;
    localparam int L  = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [31:0]   dbg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];

    dm_responder_if bus_if ();

    dm_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic ref_access(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rd, output logic exp_err);
        int idx, off, nb;
        logic [31:0] word, mask, val;
        idx = int'((addr >> 2) % DEPTH);
        off = int'(addr % 4);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_err = (off % nb) != 0;
        exp_rd  = 32'h0;
        if (exp_err) return;
        word = ref_mem[idx];
        if (we) begin
            for (int b = 0; b < nb; b++) begin
                word = word & ~(32'hFF << (8 * (off + b)));
                word = word | (((wdata >> (8 * b)) & 32'hFF) << (8 * (off + b)));
            end
            ref_mem[idx] = word;
        end else begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
            val  = (word >> (8 * off)) & mask;
            if (sext && nb < 4 && val[8*nb-1]) val = val | ~mask;
            exp_rd = val;
        end
    endtask

    task automatic drive_fields(input logic we, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.req_we    = we;
        bus_if.req_size  = size;
        bus_if.req_sext  = sext;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
    endtask

    // One complete transaction; the expected result comes from the model.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic [31:0] exp_rd, output logic exp_err);
        int n;
        @(negedge clk);
        drive_fields(we, size, sext, addr, wdata);
        bus_if.req_valid = 1'b1;
        n = 0;
        while (!bus_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ref_access(we, size, sext, addr, wdata, exp_rd, exp_err);
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        lat = 0;
        rd  = 32'hDEAD_BEEF;
        err = 1'bx;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus_if.rsp_valid) begin
                rd  = bus_if.rsp_rdata;
                err = bus_if.rsp_err;
                break;
            end
        end
        checks++;
        if (lat >= 40) begin
            errors++;
            $display("FAIL req_timeout addr=%h got no rsp_valid within %0d cycles", addr, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_if.req_valid = 1'b0;
        drive_fields(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        @(negedge clk);
        checks++;
        if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus_if.req_ready); end
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.rsp_valid !== 1'b0 || bus_if.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b valid=%b err=%b want 0", bus_if.busy, bus_if.rsp_valid, bus_if.rsp_err);
        end
        checks++;
        if (bus_if.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_if.rsp_rdata); end
        dbg_addr = 6'd4;
        #1;
        checks++;
        if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_mem got %h want 0", dbg_data); end
    endtask

    task automatic test_directed();
        logic [31:0] rd, xr;
        logic err, xe;
        int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, rd, err, lat, xr, xe);
        checks++;
        if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_word_rsp got rd=%h err=%b want 0/0", rd, err); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'h1234_5678 || err !== 1'b0) begin errors++; $display("FAIL load_word got %h err=%b want 12345678/0", rd, err); end
        checks++;
        if (lat !== L) begin errors++; $display("FAIL latency got %0d want %0d", lat, L); end
        dbg_addr = 6'd4;
        #1;
        checks++;
        if (dbg_data !== 32'h1234_5678) begin errors++; $display("FAIL dbg_word4 got %h want 12345678", dbg_data); end

        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, rd, err, lat, xr, xe);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'h1234_AB78) begin errors++; $display("FAIL byte_store_word got %h want 1234ab78", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL load_byte_sext got %h want ffffffab", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL load_byte_zext got %h want 000000ab", rd); end

        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, rd, err, lat, xr, xe);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL load_half_sext got %h want ffff8001", rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (rd !== 32'h8001_AB78) begin errors++; $display("FAIL half_store_word got %h want 8001ab78", rd); end

        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, rd, err, lat, xr, xe);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_load got rd=%h err=%b want 0/1", rd, err); end
        do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_BEEF, rd, err, lat, xr, xe);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL misaligned_store_err got %b want 1", err); end
        dbg_addr = 6'd8;
        #1;
        checks++;
        if (dbg_data !== 32'h0) begin errors++; $display("FAIL misaligned_store_mem got %h want 0", dbg_data); end
    endtask

    task automatic rand_fields(output logic we, output logic [1:0] size, output logic sext,
                               output logic [31:0] addr, output logic [31:0] wdata);
        we    = $urandom_range(0, 1) == 1;
        size  = 2'($urandom_range(0, 3));
        sext  = $urandom_range(0, 1) == 1;
        addr  = ($urandom << 8) | 32'($urandom_range(0, 31));
        wdata = $urandom;
    endtask

    task automatic test_random();
        logic [31:0] rd, xr, addr, wdata;
        logic err, xe, we, sext;
        logic [1:0] size;
        int lat;
        for (int k = 0; k < 40; k++) begin
            rand_fields(we, size, sext, addr, wdata);
            do_req(we, size, sext, addr, wdata, rd, err, lat, xr, xe);
            checks++;
            if (rd !== xr || err !== xe || lat !== L) begin
                errors++;
                $display("FAIL rand_%0d we=%b size=%0d addr=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         k, we, size, addr, rd, err, lat, xr, xe, L);
            end
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = AW'(i);
            #1;
            checks++;
            if (dbg_data !== ref_mem[i]) begin errors++; $display("FAIL rand_dbg word %0d got %h want %h", i, dbg_data, ref_mem[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q_rd[$];
        logic        q_err[$];
        logic [31:0] addr, wdata, xr, er;
        logic we, sext, xe, ee;
        logic [1:0] size;
        int last = -1;
        int gaps_bad = 0;
        int busy_bad = 0;
        int rsp_bad = 0;
        int accepts = 0;
        @(negedge clk);
        rand_fields(we, size, sext, addr, wdata);
        drive_fields(we, size, sext, addr, wdata);
        bus_if.req_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus_if.rsp_valid) begin
                if (q_rd.size() == 0) rsp_bad++;
                else begin
                    er = q_rd.pop_front();
                    ee = q_err.pop_front();
                    if (bus_if.rsp_rdata !== er || bus_if.rsp_err !== ee) rsp_bad++;
                end
            end
            if (bus_if.req_ready) begin
                if (last >= 0 && (cyc - last) != L + 1) gaps_bad++;
                last = cyc;
                accepts++;
                ref_access(we, size, sext, addr, wdata, xr, xe);
                q_rd.push_back(xr);
                q_err.push_back(xe);
                @(posedge clk);
                #1;
                rand_fields(we, size, sext, addr, wdata);
                drive_fields(we, size, sext, addr, wdata);
            end else if (bus_if.busy !== 1'b1) begin
                busy_bad++;
            end
        end
        bus_if.req_valid = 1'b0;
        for (int c = 0; c < 10 && q_rd.size() > 0; c++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) begin
                er = q_rd.pop_front();
                ee = q_err.pop_front();
                if (bus_if.rsp_rdata !== er || bus_if.rsp_err !== ee) rsp_bad++;
            end
        end
        checks++;
        if (gaps_bad != 0 || accepts < 15) begin errors++; $display("FAIL b2b_spacing bad_gaps=%0d accepts=%0d want 0 bad and >=15", gaps_bad, accepts); end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy low cycles=%0d want 0", busy_bad); end
        checks++;
        if (rsp_bad != 0 || q_rd.size() != 0) begin errors++; $display("FAIL b2b_responses bad=%0d left=%0d want 0/0", rsp_bad, q_rd.size()); end

        begin
            logic [31:0] rd;
            logic err;
            int lat;
            do_req(1'b1, 2'b10, 1'b0, (32'd4 << AW) + 32'h10, 32'hCAFE_F00D, rd, err, lat, xr, xe);
            dbg_addr = 6'd4;
            #1;
            checks++;
            if (dbg_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_store got %h want cafef00d", dbg_data); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen = 0;
        @(negedge clk);
        drive_fields(1'b1, 2'b10, 1'b0, 32'h40, 32'h5A5A_A5A5);
        bus_if.req_valid = 1'b1;
        n = 0;
        while (!bus_if.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_rsp got %0d pulses want 0", seen); end
        dbg_addr = 6'd16;
        #1;
        checks++;
        if (dbg_data !== 32'h0) begin errors++; $display("FAIL rst_mid_mem got %h want 0", dbg_data); end
        checks++;
        if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", bus_if.req_ready); end
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
